// File: rtl/axi_sram_slave.sv
// AXI-lite-style single-port SRAM responder: AW/W/B writes, AR/R reads.
// The read and write channels run as independent FSMs that share one word array.
module axi_sram_slave #(
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int unsigned DEPTH     = 4096,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned WR_LAT    = 0,
    parameter logic [63:0] OOR_DATA  = 64'hDEAD_BEEF_DEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] AW_ADDR,
    input  logic        AW_VALID,
    output logic        AW_READY,
    input  logic [63:0] W_DATA,
    input  logic [7:0]  W_STRB,
    input  logic        W_VALID,
    output logic        W_READY,
    output logic        B_VALID,
    input  logic        B_READY,
    input  logic [63:0] AR_ADDR,
    input  logic        AR_VALID,
    output logic        AR_READY,
    output logic [63:0] R_DATA,
    output logic        R_VALID,
    input  logic        R_READY,
    output logic        oor_err
);

    localparam int unsigned IDX_W       = $clog2(DEPTH);
    localparam logic [63:0] SPAN        = 64'(DEPTH) << 3;
    localparam logic [3:0]  RD_CNT_INIT = (RD_LAT > 0) ? 4'(RD_LAT - 1) : 4'd0;
    localparam logic [3:0]  WR_CNT_INIT = (WR_LAT > 0) ? 4'(WR_LAT - 1) : 4'd0;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
    typedef enum logic [1:0] {W_COLLECT, W_WAIT, W_RESP} wr_state_t;

    // An address below BASE wraps to a huge offset, so one unsigned compare covers both bounds.
    function automatic logic in_range(input logic [63:0] a);
        return (a - BASE_ADDR) < SPAN;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [63:0] a);
        return IDX_W'((a - BASE_ADDR) >> 3);
    endfunction

    function automatic logic [63:0] merge_bytes(input logic [63:0] old_w,
                                                input logic [63:0] new_w,
                                                input logic [7:0]  strb);
        logic [63:0] r;
        r = old_w;
        for (int b = 0; b < 8; b++)
            if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    logic [63:0] mem [DEPTH];

    // ---------------- write channel ----------------
    wr_state_t   wr_state, wr_state_nxt;
    logic        aw_have, w_have;
    logic [63:0] aw_addr_q, w_data_q;
    logic [7:0]  w_strb_q;
    logic [3:0]  wr_cnt;
    logic        aw_hs, w_hs, wr_commit, wr_in_range, mem_we;
    logic [63:0] wr_addr, wr_data;
    logic [7:0]  wr_strb;
    logic [IDX_W-1:0] wr_idx;

    assign AW_READY = (wr_state == W_COLLECT) && !aw_have;
    assign W_READY  = (wr_state == W_COLLECT) && !w_have;
    assign B_VALID  = (wr_state == W_RESP);
    assign aw_hs    = AW_VALID && AW_READY;
    assign w_hs     = W_VALID && W_READY;

    // A half captured earlier combines with the other half arriving now, so commit needs no extra cycle.
    assign wr_commit   = (wr_state == W_COLLECT) && (aw_have || aw_hs) && (w_have || w_hs);
    assign wr_addr     = aw_have ? aw_addr_q : AW_ADDR;
    assign wr_data     = w_have ? w_data_q : W_DATA;
    assign wr_strb     = w_have ? w_strb_q : W_STRB;
    assign wr_in_range = in_range(wr_addr);
    assign wr_idx      = word_idx(wr_addr);
    assign mem_we      = wr_commit && wr_in_range && !rst;

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
        wr_state_nxt = wr_state;
        case (wr_state)
            W_COLLECT: if (wr_commit) wr_state_nxt = (WR_LAT == 0) ? W_RESP : W_WAIT;
            W_WAIT:    if (wr_cnt == '0) wr_state_nxt = W_RESP;
            W_RESP:    if (B_READY) wr_state_nxt = W_COLLECT;
            default:   wr_state_nxt = W_COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state  <= W_COLLECT;
            aw_have   <= 1'b0;
            w_have    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            wr_cnt    <= '0;
        end else begin
            wr_state <= wr_state_nxt;
            if (aw_hs) begin
                aw_have   <= 1'b1;
                aw_addr_q <= AW_ADDR;
            end
            if (w_hs) begin
                w_have   <= 1'b1;
                w_data_q <= W_DATA;
                w_strb_q <= W_STRB;
            end
            if (wr_commit)
                wr_cnt <= WR_CNT_INIT;
            else if (wr_state == W_WAIT && wr_cnt != '0)
                wr_cnt <= wr_cnt - 1'b1;
            if (B_VALID && B_READY) begin
                aw_have <= 1'b0;
                w_have  <= 1'b0;
            end
        end
    end

    // NOTE: the array is deliberately left out of reset; contents survive rst and it can map to block RAM.
    always_ff @(posedge clk) begin
        if (mem_we)
            for (int b = 0; b < 8; b++)
                if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
    end

    // ---------------- read channel ----------------
    rd_state_t   rd_state, rd_state_nxt;
    logic [63:0] ar_addr_q, rd_addr, rd_word;
    logic [3:0]  rd_cnt;
    logic        rd_load, rd_in_range;
    logic [IDX_W-1:0] rd_idx;

    always_comb begin
        rd_state_nxt = rd_state;
        rd_load      = 1'b0;
        rd_addr      = ar_addr_q;
        AR_READY     = 1'b0;
        R_VALID      = 1'b0;
        case (rd_state)
            R_IDLE: begin
                AR_READY = 1'b1;
                rd_addr  = AR_ADDR;
                if (AR_VALID) begin
                    if (RD_LAT == 0) begin
                        rd_state_nxt = R_RESP;
                        rd_load      = 1'b1;
                    end else begin
                        rd_state_nxt = R_WAIT;
                    end
                end
            end
            R_WAIT: if (rd_cnt == '0) begin
                rd_state_nxt = R_RESP;
                rd_load      = 1'b1;
            end
            R_RESP: begin
                R_VALID = 1'b1;
                if (R_READY) rd_state_nxt = R_IDLE;
            end
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    assign rd_in_range = in_range(rd_addr);
    assign rd_idx      = word_idx(rd_addr);

    // Write-before-read: a commit to the same word on the load edge is merged into the returned data.
    always_comb begin
        rd_word = mem[rd_idx];
        if (wr_commit && wr_in_range && wr_idx == rd_idx)
            rd_word = merge_bytes(rd_word, wr_data, wr_strb);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state  <= R_IDLE;
            ar_addr_q <= '0;
            rd_cnt    <= '0;
            R_DATA    <= '0;
            oor_err   <= 1'b0;
        end else begin
            rd_state <= rd_state_nxt;
            if (rd_state == R_IDLE && AR_VALID) begin
                ar_addr_q <= AR_ADDR;
                rd_cnt    <= RD_CNT_INIT;
            end else if (rd_state == R_WAIT && rd_cnt != '0) begin
                rd_cnt <= rd_cnt - 1'b1;
            end
            if (rd_load)
                R_DATA <= rd_in_range ? rd_word : OOR_DATA;
            oor_err <= (rd_load && !rd_in_range) || (wr_commit && !wr_in_range);
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: a vector table of single transactions plus
// hand-written sequences for ordering, backpressure, collision and reset corners.
module tb_axi_sram_slave;

    localparam int unsigned RD_LAT   = 1;
    localparam int unsigned WR_LAT   = 0;
    localparam logic [63:0] OOR_DATA = 64'hDEAD_BEEF_DEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] aw_addr, w_data, ar_addr;
    logic [7:0]  w_strb;
    logic        aw_valid, w_valid, b_ready, ar_valid, r_ready;
    logic        aw_ready, w_ready, b_valid, ar_ready, r_valid, oor_err;
    logic [63:0] r_data;

    // Second instance with RD_LAT=0 shares the write channel and read address; used for collision.
    logic        z_ar_valid, z_r_ready;
    logic        z_aw_ready, z_w_ready, z_b_valid, z_ar_ready, z_r_valid, z_oor_err;
    logic [63:0] z_r_data;

    int total = 0;
    int bad   = 0;
    int oor_cnt = 0;

    always #5 clk = ~clk;

    axi_sram_slave #(.RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) u_dut (
        .clk(clk), .rst(rst),
        .AW_ADDR(aw_addr), .AW_VALID(aw_valid), .AW_READY(aw_ready),
        .W_DATA(w_data), .W_STRB(w_strb), .W_VALID(w_valid), .W_READY(w_ready),
        .B_VALID(b_valid), .B_READY(b_ready),
        .AR_ADDR(ar_addr), .AR_VALID(ar_valid), .AR_READY(ar_ready),
        .R_DATA(r_data), .R_VALID(r_valid), .R_READY(r_ready),
        .oor_err(oor_err)
    );

    axi_sram_slave #(.RD_LAT(0), .WR_LAT(WR_LAT)) u_dut0 (
        .clk(clk), .rst(rst),
        .AW_ADDR(aw_addr), .AW_VALID(aw_valid), .AW_READY(z_aw_ready),
        .W_DATA(w_data), .W_STRB(w_strb), .W_VALID(w_valid), .W_READY(z_w_ready),
        .B_VALID(z_b_valid), .B_READY(b_ready),
        .AR_ADDR(ar_addr), .AR_VALID(z_ar_valid), .AR_READY(z_ar_ready),
        .R_DATA(z_r_data), .R_VALID(z_r_valid), .R_READY(z_r_ready),
        .oor_err(z_oor_err)
    );

    // Count oor_err pulses just after each edge; a stuck-high pulse counts more than once.
    always begin
        @(posedge clk);
        #1;
        if (oor_err === 1'b1) oor_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [63:0] a, input logic [63:0] d,
                            input logic [7:0] s, input logic exp_oor);
        int lat;
        int o0;
        o0 = oor_cnt;
        check("aw_ready idle", 64'(aw_ready), 64'd1);
        check("w_ready idle", 64'(w_ready), 64'd1);
        aw_addr  = a;
        w_data   = d;
        w_strb   = s;
        aw_valid = 1'b1;
        w_valid  = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            aw_valid = 1'b0;
            w_valid  = 1'b0;
            lat++;
        end while (!b_valid && lat < 20);
        check("b latency", 64'(lat), 64'(WR_LAT + 1));
        check("aw_ready while b pending", 64'(aw_ready), 64'd0);
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
        check("b_valid after handshake", 64'(b_valid), 64'd0);
        check("write oor pulses", 64'(oor_cnt - o0), 64'(exp_oor));
    endtask

    task automatic do_read(input logic [63:0] a, input logic [63:0] exp, input logic exp_oor);
        int lat;
        int o0;
        o0 = oor_cnt;
        check("ar_ready idle", 64'(ar_ready), 64'd1);
        ar_addr  = a;
        ar_valid = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            ar_valid = 1'b0;
            lat++;
        end while (!r_valid && lat < 20);
        check("r latency", 64'(lat), 64'(RD_LAT + 1));
        check("r_data", r_data, exp);
        r_ready = 1'b1;
        @(negedge clk);
        r_ready = 1'b0;
        check("r_valid after handshake", 64'(r_valid), 64'd0);
        check("ar_ready after handshake", 64'(ar_ready), 64'd1);
        check("read oor pulses", 64'(oor_cnt - o0), 64'(exp_oor));
    endtask

    typedef struct packed {
        logic        is_wr;
        logic [63:0] addr;
        logic [63:0] data;   // write data, or expected read data
        logic [7:0]  strb;
        logic        oor;
    } vec_t;

    vec_t vecs [13];

    initial begin
        vecs[0]  = '{1'b1, 64'h8000_0000, 64'hAAAA_BBBB_CCCC_DDDD, 8'hFF, 1'b0};
        vecs[1]  = '{1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 1'b0};
        vecs[2]  = '{1'b0, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'h00, 1'b0};
        vecs[3]  = '{1'b1, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1'b0};
        vecs[4]  = '{1'b0, 64'h8000_0000, 64'hAAAA_BBBB_CCCC_DDDD, 8'h00, 1'b0};
        vecs[5]  = '{1'b1, 64'h8000_0000, 64'h1111_2222_3333_4444, 8'h0F, 1'b0};
        vecs[6]  = '{1'b0, 64'h8000_0004, 64'hAAAA_BBBB_3333_4444, 8'h00, 1'b0};
        vecs[7]  = '{1'b1, 64'h8000_7FF8, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0};
        vecs[8]  = '{1'b0, 64'h8000_7FFF, 64'h0123_4567_89AB_CDEF, 8'h00, 1'b0};
        vecs[9]  = '{1'b1, 64'h8000_8000, 64'h5555_5555_5555_5555, 8'hFF, 1'b1};
        vecs[10] = '{1'b0, 64'h8000_0000, 64'hAAAA_BBBB_3333_4444, 8'h00, 1'b0};
        vecs[11] = '{1'b0, 64'h7FFF_FFF8, OOR_DATA,                8'h00, 1'b1};
        vecs[12] = '{1'b0, 64'h8000_8000, OOR_DATA,                8'h00, 1'b1};

        rst = 1'b1;
        aw_addr = '0; w_data = '0; w_strb = '0; ar_addr = '0;
        aw_valid = 1'b0; w_valid = 1'b0; b_ready = 1'b0; ar_valid = 1'b0; r_ready = 1'b0;
        z_ar_valid = 1'b0; z_r_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("reset aw_ready", 64'(aw_ready), 64'd1);
        check("reset w_ready", 64'(w_ready), 64'd1);
        check("reset ar_ready", 64'(ar_ready), 64'd1);
        check("reset b_valid", 64'(b_valid), 64'd0);
        check("reset r_valid", 64'(r_valid), 64'd0);
        check("reset r_data", r_data, 64'd0);
        check("reset oor_err", 64'(oor_err), 64'd0);
        check("reset r_data lat0", z_r_data, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].is_wr)
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].oor);
            else
                do_read(vecs[i].addr, vecs[i].data, vecs[i].oor);
        end

        // W arrives three cycles ahead of AW; commit must wait for the address.
        w_data  = 64'h0000_0000_0000_00AB;
        w_strb  = 8'h01;
        w_valid = 1'b1;
        @(negedge clk);
        w_valid = 1'b0;
        check("w-first w_ready", 64'(w_ready), 64'd0);
        check("w-first aw_ready", 64'(aw_ready), 64'd1);
        repeat (2) @(negedge clk);
        check("w-first no early b", 64'(b_valid), 64'd0);
        aw_addr  = 64'h8000_0010;
        aw_valid = 1'b1;
        @(negedge clk);
        aw_valid = 1'b0;
        check("w-first b after aw", 64'(b_valid), 64'd1);
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
        do_read(64'h8000_0010, 64'h1122_3344_5566_77AB, 1'b0);

        // R_READY held low while AR_VALID toggles: response stays put, no second read taken.
        ar_addr  = 64'h8000_0010;
        ar_valid = 1'b1;
        @(negedge clk);
        ar_valid = 1'b0;
        @(negedge clk);
        check("bp r_valid up", 64'(r_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            ar_addr  = 64'h8000_0000;
            ar_valid = (i % 2 == 0);
            @(negedge clk);
            check("bp r_valid held", 64'(r_valid), 64'd1);
            check("bp r_data held", r_data, 64'h1122_3344_5566_77AB);
            check("bp ar_ready low", 64'(ar_ready), 64'd0);
        end
        ar_valid = 1'b0;
        r_ready  = 1'b1;
        @(negedge clk);
        r_ready = 1'b0;
        check("bp r_valid drop", 64'(r_valid), 64'd0);
        repeat (2) @(negedge clk);
        check("bp no extra read", 64'(r_valid), 64'd0);

        // Same-edge read and write to index 5 on the RD_LAT=0 instance.
        do_write(64'h8000_0028, 64'h0102_0304_0506_0708, 8'hFF, 1'b0);
        check("coll ar_ready", 64'(z_ar_ready), 64'd1);
        ar_addr    = 64'h8000_0028;
        z_ar_valid = 1'b1;
        aw_addr    = 64'h8000_0028;
        w_data     = 64'hF1F2_F3F4_F5F6_F7F8;
        w_strb     = 8'hF0;
        aw_valid   = 1'b1;
        w_valid    = 1'b1;
        @(negedge clk);
        z_ar_valid = 1'b0;
        aw_valid   = 1'b0;
        w_valid    = 1'b0;
        check("coll r_valid", 64'(z_r_valid), 64'd1);
        check("coll r_data merged", z_r_data, 64'hF1F2_F3F4_0506_0708);
        check("coll b_valid", 64'(b_valid), 64'd1);
        b_ready   = 1'b1;
        z_r_ready = 1'b1;
        @(negedge clk);
        b_ready   = 1'b0;
        z_r_ready = 1'b0;
        check("coll r_valid drop", 64'(z_r_valid), 64'd0);
        do_read(64'h8000_0028, 64'hF1F2_F3F4_0506_0708, 1'b0);

        // Reset during R_WAIT with only AW captured.
        ar_addr  = 64'h8000_0010;
        ar_valid = 1'b1;
        aw_addr  = 64'h8000_0010;
        aw_valid = 1'b1;
        @(negedge clk);
        ar_valid = 1'b0;
        aw_valid = 1'b0;
        check("mid ar_ready busy", 64'(ar_ready), 64'd0);
        check("mid aw captured", 64'(aw_ready), 64'd0);
        #1 rst = 1'b1;
        #1;
        check("rst aw_ready", 64'(aw_ready), 64'd1);
        check("rst w_ready", 64'(w_ready), 64'd1);
        check("rst ar_ready", 64'(ar_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post-rst r_valid", 64'(r_valid), 64'd0);
            check("post-rst b_valid", 64'(b_valid), 64'd0);
        end
        // The dropped AW must not pair with a fresh W.
        w_data  = 64'd0;
        w_strb  = 8'hFF;
        w_valid = 1'b1;
        @(negedge clk);
        w_valid = 1'b0;
        @(negedge clk);
        check("post-rst w alone no b", 64'(b_valid), 64'd0);
        aw_addr  = 64'h8000_0030;
        aw_valid = 1'b1;
        @(negedge clk);
        aw_valid = 1'b0;
        check("post-rst b after aw", 64'(b_valid), 64'd1);
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
        do_read(64'h8000_0010, 64'h1122_3344_5566_77AB, 1'b0);
        do_read(64'h8000_0030, 64'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
